// File: rtl/time_uart_reporter.sv
// Sends the snapshotted watch time as "HH:MM:SS.CC\r\n" over an 8N1 UART line.
// One frame per accepted request; requests arriving while busy are dropped.
module time_uart_reporter #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic       auto_en,
    input  logic       tick_1s,
    input  logic [3:0] digit_hour_10,
    input  logic [3:0] digit_hour_1,
    input  logic [3:0] digit_min_10,
    input  logic [3:0] digit_min_1,
    input  logic [3:0] digit_sec_10,
    input  logic [3:0] digit_sec_1,
    input  logic [3:0] digit_msec_10,
    input  logic [3:0] digit_msec_1,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int DIV         = CLK_FREQ / BAUD;
    localparam int CNT_W       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NUM_DIGITS  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [3:0]       BYTE_LAST = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [3:0]       byte_idx_reg;
    logic             tx_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [3:0] digit_in   [NUM_DIGITS];
    logic [3:0] snap_reg   [NUM_DIGITS];
    logic [7:0] digit_char [NUM_DIGITS];

    logic       req;
    logic       accept;
    logic       cnt_last;
    logic [2:0] bit_next;
    logic [7:0] cur_byte;

    assign digit_in[0] = digit_hour_10;
    assign digit_in[1] = digit_hour_1;
    assign digit_in[2] = digit_min_10;
    assign digit_in[3] = digit_min_1;
    assign digit_in[4] = digit_sec_10;
    assign digit_in[5] = digit_sec_1;
    assign digit_in[6] = digit_msec_10;
    assign digit_in[7] = digit_msec_1;

    assign req      = send | (auto_en & tick_1s);
    assign accept   = (state_reg == S_IDLE) & req;
    assign cnt_last = (cnt_reg == CNT_LAST);
    assign bit_next = bit_idx_reg + 3'd1;

    // Digits are frozen at accept so a frame always shows one consistent time.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            always_ff @(posedge clk) begin
                if (reset) begin
                    snap_reg[gi] <= 4'd0;
                end else if (accept) begin
                    snap_reg[gi] <= digit_in[gi];
                end
            end

            assign digit_char[gi] = (snap_reg[gi] <= 4'd9)
                                    ? (8'h30 + {4'h0, snap_reg[gi]})
                                    : 8'h3F;
        end
    endgenerate

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx_reg)
            4'd0:    cur_byte = digit_char[0];
            4'd1:    cur_byte = digit_char[1];
            4'd2:    cur_byte = 8'h3A;
            4'd3:    cur_byte = digit_char[2];
            4'd4:    cur_byte = digit_char[3];
            4'd5:    cur_byte = 8'h3A;
            4'd6:    cur_byte = digit_char[4];
            4'd7:    cur_byte = digit_char[5];
            4'd8:    cur_byte = 8'h2E;
            4'd9:    cur_byte = digit_char[6];
            4'd10:   cur_byte = digit_char[7];
            4'd11:   cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // tx is registered and loaded one state ahead, so each bit starts on the
    // same edge as the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= 3'd0;
            byte_idx_reg <= 4'd0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                    if (req) begin
                        state_reg    <= S_START;
                        cnt_reg      <= '0;
                        bit_idx_reg  <= 3'd0;
                        byte_idx_reg <= 4'd0;
                        tx_reg       <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt_last) begin
                        state_reg   <= S_DATA;
                        cnt_reg     <= '0;
                        bit_idx_reg <= 3'd0;
                        tx_reg      <= cur_byte[0];
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt_last) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= S_STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_next;
                            tx_reg      <= cur_byte[bit_next];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cnt_last) begin
                        cnt_reg <= '0;
                        if (byte_idx_reg < BYTE_LAST) begin
                            byte_idx_reg <= byte_idx_reg + 4'd1;
                            state_reg    <= S_START;
                            tx_reg       <= 1'b0;
                        end else begin
                            state_reg <= S_IDLE;
                            tx_reg    <= 1'b1;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    cnt_reg   <= '0;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule
